// File: rtl/kronos_wb_stage.sv
// kronos_wb_stage: register write-back stage of the Kronos core.
// Accepts execute results over valid/ready, performs data-bus reads for
// loads (align + sign/zero extend) and drives the register-file write port.
// Ports:
//   clk, rstz                        : clock, async active-low reset
//   execute_vld/execute_rdy          : result handshake from execute
//   ex_rd, ex_rd_en, ex_load,
//   ex_funct3, ex_result             : result payload / load address
//   data_addr, data_req, data_ack,
//   data_rd_data                     : load data bus
//   regwr_sel, regwr_data, regwr_en  : register-file write port
//   regwr_pending                    : write accepted but not yet retired
//   load_misaligned, bus_timeout     : single-cycle event pulses
// Latency: ALU results strobe 1 cycle after accept; loads 1 cycle after data_ack.
// Backpressure: execute_rdy is low for the whole time a load is outstanding.
// Optional: define KRONOS_WB_MISALIGN_TRAP_EN to trap misaligned LH/LHU/LW.
module kronos_wb_stage #(
   parameter int BUS_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rstz,
   input  logic        execute_vld,
   output logic        execute_rdy,
   input  logic [4:0]  ex_rd,
   input  logic        ex_rd_en,
   input  logic        ex_load,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_result,
   output logic [31:0] data_addr,
   output logic        data_req,
   input  logic        data_ack,
   input  logic [31:0] data_rd_data,
   output logic [4:0]  regwr_sel,
   output logic [31:0] regwr_data,
   output logic        regwr_en,
   output logic        regwr_pending,
   output logic        load_misaligned,
   output logic        bus_timeout
);

   typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

   localparam bit          TO_EN   = (BUS_TIMEOUT > 0);
   localparam logic [31:0] TO_LAST = TO_EN ? 32'(BUS_TIMEOUT - 1) : 32'd0;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [4:0]  rd_q, rd_d;
   logic        wen_q, wen_d;          // latched "write is effective"
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [29:0] addr_q, addr_d;
   logic        regwr_en_q, regwr_en_d;
   logic [4:0]  sel_q, sel_d;
   logic [31:0] data_q, data_d;
   logic        pending_q, pending_d;
   logic        timeout_q, timeout_d;
   logic        mis_q, mis_d;

   logic        accept;
   logic        eff;
   logic        misalign_det;
   logic [31:0] rot;
   logic [31:0] load_data;

   assign accept = execute_vld & execute_rdy;
   assign eff    = ex_rd_en & (ex_rd != 5'd0);

`ifdef KRONOS_WB_MISALIGN_TRAP_EN
   assign misalign_det = ((ex_funct3[1:0] == 2'b01) & ex_result[0]) |
                         ((ex_funct3 == 3'b010) & (ex_result[1:0] != 2'b00));
`else
   assign misalign_det = 1'b0;
`endif

   // Rotate (not shift) so misaligned loads wrap around within the word.
   always_comb begin
      rot = data_rd_data;
      case (off_q)
         2'd1:    rot = {data_rd_data[7:0],  data_rd_data[31:8]};
         2'd2:    rot = {data_rd_data[15:0], data_rd_data[31:16]};
         2'd3:    rot = {data_rd_data[23:0], data_rd_data[31:24]};
         default: rot = data_rd_data;
      endcase
   end

   always_comb begin
      case (f3_q)
         3'b000:  load_data = {{24{rot[7]}}, rot[7:0]};
         3'b001:  load_data = {{16{rot[15]}}, rot[15:0]};
         3'b100:  load_data = {24'd0, rot[7:0]};
         3'b101:  load_data = {16'd0, rot[15:0]};
         default: load_data = rot;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_d       = rd_q;
      wen_d      = wen_q;
      f3_d       = f3_q;
      off_d      = off_q;
      addr_d     = addr_q;
      regwr_en_d = 1'b0;
      sel_d      = sel_q;
      data_d     = data_q;
      pending_d  = pending_q;
      timeout_d  = 1'b0;
      mis_d      = 1'b0;

      // Strobe cycle retires the pending write; a new effective accept
      // below re-asserts it so there is no gap.
      if (regwr_en_q) pending_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (ex_load) begin
                  if (misalign_det) begin
                     mis_d = 1'b1;
                  end else begin
                     state_d = LOAD;
                     cnt_d   = 32'd0;
                     rd_d    = ex_rd;
                     wen_d   = eff;
                     f3_d    = ex_funct3;
                     off_d   = ex_result[1:0];
                     addr_d  = ex_result[31:2];
                     if (eff) pending_d = 1'b1;
                  end
               end else if (eff) begin
                  regwr_en_d = 1'b1;
                  sel_d      = ex_rd;
                  data_d     = ex_result;
                  pending_d  = 1'b1;
               end
            end
         end
         LOAD: begin
            if (data_ack) begin
               state_d = IDLE;
               if (wen_q) begin
                  regwr_en_d = 1'b1;
                  sel_d      = rd_q;
                  data_d     = load_data;
               end
            end else if (TO_EN && (cnt_q == TO_LAST)) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
               pending_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         state_q    <= IDLE;
         cnt_q      <= 32'd0;
         rd_q       <= 5'd0;
         wen_q      <= 1'b0;
         f3_q       <= 3'd0;
         off_q      <= 2'd0;
         addr_q     <= 30'd0;
         regwr_en_q <= 1'b0;
         sel_q      <= 5'd0;
         data_q     <= 32'd0;
         pending_q  <= 1'b0;
         timeout_q  <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         wen_q      <= wen_d;
         f3_q       <= f3_d;
         off_q      <= off_d;
         addr_q     <= addr_d;
         regwr_en_q <= regwr_en_d;
         sel_q      <= sel_d;
         data_q     <= data_d;
         pending_q  <= pending_d;
         timeout_q  <= timeout_d;
         mis_q      <= mis_d;
      end
   end

   assign execute_rdy   = (state_q == IDLE);
   assign data_req      = (state_q == LOAD);
   assign data_addr     = {addr_q, 2'b00};
   assign regwr_sel     = sel_q;
   assign regwr_data    = data_q;
   assign regwr_en      = regwr_en_q;
   assign regwr_pending = pending_q;
   assign bus_timeout   = timeout_q;
`ifdef KRONOS_WB_MISALIGN_TRAP_EN
   assign load_misaligned = mis_q;
`else
   assign load_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_kronos_wb_stage.sv
// Directed testbench for kronos_wb_stage (BUS_TIMEOUT=4).
module tb_kronos_wb_stage;

   logic        clk = 1'b0;
   logic        rstz;
   logic        execute_vld;
   logic        execute_rdy;
   logic [4:0]  ex_rd;
   logic        ex_rd_en;
   logic        ex_load;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_result;
   logic [31:0] data_addr;
   logic        data_req;
   logic        data_ack;
   logic [31:0] data_rd_data;
   logic [4:0]  regwr_sel;
   logic [31:0] regwr_data;
   logic        regwr_en;
   logic        regwr_pending;
   logic        load_misaligned;
   logic        bus_timeout;

   int errors = 0;
   int checks = 0;

   kronos_wb_stage #(.BUS_TIMEOUT(4)) dut (
      .clk            (clk),
      .rstz           (rstz),
      .execute_vld    (execute_vld),
      .execute_rdy    (execute_rdy),
      .ex_rd          (ex_rd),
      .ex_rd_en       (ex_rd_en),
      .ex_load        (ex_load),
      .ex_funct3      (ex_funct3),
      .ex_result      (ex_result),
      .data_addr      (data_addr),
      .data_req       (data_req),
      .data_ack       (data_ack),
      .data_rd_data   (data_rd_data),
      .regwr_sel      (regwr_sel),
      .regwr_data     (regwr_data),
      .regwr_en       (regwr_en),
      .regwr_pending  (regwr_pending),
      .load_misaligned(load_misaligned),
      .bus_timeout    (bus_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic vld, input logic [4:0] rd, input logic rd_en,
                        input logic ld, input logic [2:0] f3, input logic [31:0] res);
      execute_vld = vld;
      ex_rd       = rd;
      ex_rd_en    = rd_en;
      ex_load     = ld;
      ex_funct3   = f3;
      ex_result   = res;
   endtask

   initial begin
      rstz = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      data_ack     = 1'b0;
      data_rd_data = 32'd0;
      #12;
      // ---- reset state
      chk("rst_rdy",  32'(execute_rdy), 32'd1);
      chk("rst_req",  32'(data_req), 32'd0);
      chk("rst_wen",  32'(regwr_en), 32'd0);
      chk("rst_pend", 32'(regwr_pending), 32'd0);
      chk("rst_sel",  32'(regwr_sel), 32'd0);
      chk("rst_data", regwr_data, 32'd0);
      chk("rst_to",   32'(bus_timeout), 32'd0);
      chk("rst_mis",  32'(load_misaligned), 32'd0);
      @(negedge clk);
      rstz = 1'b1;
      tick();

      // ---- ALU burst rd=1,2,3
      drive(1'b1, 5'd1, 1'b1, 1'b0, 3'd0, 32'h11);
      tick();
      chk("burst1_wen",  32'(regwr_en), 32'd1);
      chk("burst1_sel",  32'(regwr_sel), 32'd1);
      chk("burst1_data", regwr_data, 32'h11);
      chk("burst1_pend", 32'(regwr_pending), 32'd1);
      drive(1'b1, 5'd2, 1'b1, 1'b0, 3'd0, 32'h22);
      tick();
      chk("burst2_wen",  32'(regwr_en), 32'd1);
      chk("burst2_sel",  32'(regwr_sel), 32'd2);
      chk("burst2_data", regwr_data, 32'h22);
      chk("burst2_pend", 32'(regwr_pending), 32'd1);
      drive(1'b1, 5'd3, 1'b1, 1'b0, 3'd0, 32'h33);
      tick();
      chk("burst3_wen",  32'(regwr_en), 32'd1);
      chk("burst3_sel",  32'(regwr_sel), 32'd3);
      chk("burst3_data", regwr_data, 32'h33);
      chk("burst3_pend", 32'(regwr_pending), 32'd1);
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      tick();
      chk("burst_end_wen",  32'(regwr_en), 32'd0);
      chk("burst_end_pend", 32'(regwr_pending), 32'd0);
      chk("burst_hold_sel", 32'(regwr_sel), 32'd3);
      chk("burst_hold_dat", regwr_data, 32'h33);

      // ---- non-effective writes
      drive(1'b1, 5'd0, 1'b1, 1'b0, 3'd0, 32'h55);
      tick();
      chk("rd0_wen",  32'(regwr_en), 32'd0);
      chk("rd0_pend", 32'(regwr_pending), 32'd0);
      chk("rd0_hold", regwr_data, 32'h33);
      drive(1'b1, 5'd5, 1'b0, 1'b0, 3'd0, 32'h66);
      tick();
      chk("noen_wen",  32'(regwr_en), 32'd0);
      chk("noen_pend", 32'(regwr_pending), 32'd0);

      // ---- LB at 0x1003, ack in second request cycle
      drive(1'b1, 5'd4, 1'b1, 1'b1, 3'b000, 32'h1003);
      tick();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      chk("lb_req1",  32'(data_req), 32'd1);
      chk("lb_addr",  data_addr, 32'h1000);
      chk("lb_rdy1",  32'(execute_rdy), 32'd0);
      chk("lb_pend1", 32'(regwr_pending), 32'd1);
      chk("lb_wen1",  32'(regwr_en), 32'd0);
      tick();
      chk("lb_req2",  32'(data_req), 32'd1);
      chk("lb_rdy2",  32'(execute_rdy), 32'd0);
      chk("lb_addr2", data_addr, 32'h1000);
      data_ack = 1'b1;
      data_rd_data = 32'h80FF_0000;
      tick();
      data_ack = 1'b0;
      chk("lb_wen",  32'(regwr_en), 32'd1);
      chk("lb_sel",  32'(regwr_sel), 32'd4);
      chk("lb_data", regwr_data, 32'hFFFF_FF80);
      chk("lb_pend", 32'(regwr_pending), 32'd1);
      chk("lb_req_off", 32'(data_req), 32'd0);
      chk("lb_rdy_back", 32'(execute_rdy), 32'd1);
      tick();
      chk("lb_wen_off",  32'(regwr_en), 32'd0);
      chk("lb_pend_off", 32'(regwr_pending), 32'd0);

      // ---- LHU offset 2, same-cycle ack, then accept in strobe cycle
      drive(1'b1, 5'd6, 1'b1, 1'b1, 3'b101, 32'h3002);
      tick();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      chk("lhu_req",  32'(data_req), 32'd1);
      chk("lhu_addr", data_addr, 32'h3000);
      chk("lhu_pend", 32'(regwr_pending), 32'd1);
      data_ack = 1'b1;
      data_rd_data = 32'hBEEF_1234;
      tick();
      data_ack = 1'b0;
      chk("lhu_wen",  32'(regwr_en), 32'd1);
      chk("lhu_data", regwr_data, 32'h0000_BEEF);
      chk("lhu_sel",  32'(regwr_sel), 32'd6);
      chk("lhu_pend2", 32'(regwr_pending), 32'd1);
      chk("lhu_rdy",  32'(execute_rdy), 32'd1);
      drive(1'b1, 5'd7, 1'b1, 1'b0, 3'd0, 32'h77);
      tick();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      chk("strobe_acc_wen",  32'(regwr_en), 32'd1);
      chk("strobe_acc_data", regwr_data, 32'h77);
      chk("strobe_acc_pend", 32'(regwr_pending), 32'd1);
      tick();
      chk("strobe_acc_pend_off", 32'(regwr_pending), 32'd0);

      // ---- timeout after 4 request cycles
      drive(1'b1, 5'd8, 1'b1, 1'b1, 3'b010, 32'h4000);
      tick();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      chk("to_req1", 32'(data_req), 32'd1);
      tick();
      chk("to_req2", 32'(data_req), 32'd1);
      tick();
      chk("to_req3", 32'(data_req), 32'd1);
      tick();
      chk("to_req4", 32'(data_req), 32'd1);
      chk("to_pulse_early", 32'(bus_timeout), 32'd0);
      tick();
      chk("to_req_off", 32'(data_req), 32'd0);
      chk("to_pulse",   32'(bus_timeout), 32'd1);
      chk("to_rdy",     32'(execute_rdy), 32'd1);
      chk("to_wen",     32'(regwr_en), 32'd0);
      chk("to_pend",    32'(regwr_pending), 32'd0);
      data_ack = 1'b1;
      data_rd_data = 32'h1234_5678;
      tick();
      data_ack = 1'b0;
      chk("late_ack_pulse", 32'(bus_timeout), 32'd0);
      chk("late_ack_wen",   32'(regwr_en), 32'd0);
      chk("late_ack_req",   32'(data_req), 32'd0);
      chk("late_ack_hold",  regwr_data, 32'h77);

      // ---- LW at 0x2002
      drive(1'b1, 5'd9, 1'b1, 1'b1, 3'b010, 32'h2002);
      tick();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
`ifdef KRONOS_WB_MISALIGN_TRAP_EN
      chk("mis_req",   32'(data_req), 32'd0);
      chk("mis_pulse", 32'(load_misaligned), 32'd1);
      chk("mis_pend",  32'(regwr_pending), 32'd0);
      chk("mis_rdy",   32'(execute_rdy), 32'd1);
      tick();
      chk("mis_pulse_off", 32'(load_misaligned), 32'd0);
      chk("mis_wen",   32'(regwr_en), 32'd0);
      chk("mis_req2",  32'(data_req), 32'd0);
`else
      chk("rot_req",  32'(data_req), 32'd1);
      chk("rot_addr", data_addr, 32'h2000);
      chk("rot_mis",  32'(load_misaligned), 32'd0);
      data_ack = 1'b1;
      data_rd_data = 32'h4433_2211;
      tick();
      data_ack = 1'b0;
      chk("rot_wen",  32'(regwr_en), 32'd1);
      chk("rot_data", regwr_data, 32'h2211_4433);
      tick();
`endif

      // ---- reset in the middle of a load
      drive(1'b1, 5'd10, 1'b1, 1'b1, 3'b010, 32'h5000);
      tick();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      chk("mid_req_pre", 32'(data_req), 32'd1);
      rstz = 1'b0;
      #1;
      chk("mid_req",  32'(data_req), 32'd0);
      chk("mid_rdy",  32'(execute_rdy), 32'd1);
      chk("mid_pend", 32'(regwr_pending), 32'd0);
      data_ack = 1'b1;
      data_rd_data = 32'hAAAA_AAAA;
      @(negedge clk);
      data_ack = 1'b0;
      rstz = 1'b1;
      tick();
      chk("mid_wen",  32'(regwr_en), 32'd0);
      chk("mid_data", regwr_data, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
